pipe_hazard_unit: RTL and testbench

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

---
 rtl/pipe_hazard_unit.sv | 172 +++++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipe_hazard_unit
//
// Hazard detection and forwarding control for a classic 5-stage pipeline.
// The unit keeps its own shadow copy of what sits in EX, MEM and WB. It then
// derives the stall, flush, EX forwarding and ID bypass selects from that
// copy and from the instruction currently in ID.
//
// Parameters
//   REG_AW   register address width
//   FWD_EN   1: forwarding/bypass, stall only on load-use
//            0: no forwarding, stall on any in-flight writer
//   ZERO_R0  1: register 0 is hardwired zero and never creates a dependency
//   CNT_W    width of the saturating event counters
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_valid                    ID holds a real instruction
//   id_rs, id_rt                ID source registers
//   id_rs_used, id_rt_used      source register is actually read
//   id_rd                       ID destination register
//   id_reg_write, id_mem_read   ID control bits
//   br_taken                    instruction in EX redirects the PC this cycle
//   stall                       hold PC and IF/ID, bubble into ID/EX
//   flush_ifid, flush_idex      squash those pipeline registers
//   ex_fwd_a, ex_fwd_b          00 ID/EX, 01 EX/MEM ALU result, 10 MEM/WB data
//   id_byp_a, id_byp_b          use write-back data instead of the RF read
//   stall_cnt, flush_cnt        saturating event counters
// -----------------------------------------------------------------------------
module pipe_hazard_unit #(
    parameter int REG_AW  = 6,
    parameter bit FWD_EN  = 1'b1,
    parameter bit ZERO_R0 = 1'b0,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              br_taken,
    output logic              stall,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic [1:0]        ex_fwd_a,
    output logic [1:0]        ex_fwd_b,
    output logic              id_byp_a,
    output logic              id_byp_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // EX needs the full instruction: its sources drive forwarding and its
    // mem_read flags a load-use. Past EX nothing reads the sources or the
    // load flag any more, so MEM and WB only keep the writer identity.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              rs_used;
        logic              rt_used;
    } ex_stage_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
    } wr_stage_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ex_stage_t        ex_q;
    wr_stage_t        mem_q;
    wr_stage_t        wb_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // A stage writes register r only if it is a real, register-writing
    // instruction targeting r. valid comes first so that an X rd left in a
    // bubble can never turn into a match.
    function automatic logic writes(input logic v, input logic w,
                                    input logic [REG_AW-1:0] d,
                                    input logic [REG_AW-1:0] r);
        return v && w && (d == r) && !(ZERO_R0 && (r == '0));
    endfunction

    logic id_a_live, id_b_live, ex_a_live, ex_b_live;
    logic hz_ex, hz_mem, hz_wb, stall_raw;
    logic mem_wr_a, mem_wr_b, wb_wr_a, wb_wr_b;

    always_comb begin
        id_a_live = id_valid && id_rs_used;
        id_b_live = id_valid && id_rt_used;
        ex_a_live = ex_q.valid && ex_q.rs_used;
        ex_b_live = ex_q.valid && ex_q.rt_used;

        hz_ex  = (id_a_live && writes(ex_q.valid, ex_q.reg_write, ex_q.rd, id_rs)) ||
                 (id_b_live && writes(ex_q.valid, ex_q.reg_write, ex_q.rd, id_rt));
        hz_mem = (id_a_live && writes(mem_q.valid, mem_q.reg_write, mem_q.rd, id_rs)) ||
                 (id_b_live && writes(mem_q.valid, mem_q.reg_write, mem_q.rd, id_rt));
        hz_wb  = (id_a_live && writes(wb_q.valid, wb_q.reg_write, wb_q.rd, id_rs)) ||
                 (id_b_live && writes(wb_q.valid, wb_q.reg_write, wb_q.rd, id_rt));

        // With forwarding only a load in EX is too late to forward from.
        stall_raw = FWD_EN ? (hz_ex && ex_q.mem_read) : (hz_ex || hz_mem || hz_wb);

        // A taken branch squashes ID anyway, so it overrides the stall.
        stall      = rst_n && !br_taken && stall_raw;
        flush_ifid = rst_n && br_taken;
        flush_idex = rst_n && br_taken;

        mem_wr_a = ex_a_live && writes(mem_q.valid, mem_q.reg_write, mem_q.rd, ex_q.rs);
        mem_wr_b = ex_b_live && writes(mem_q.valid, mem_q.reg_write, mem_q.rd, ex_q.rt);
        wb_wr_a  = ex_a_live && writes(wb_q.valid, wb_q.reg_write, wb_q.rd, ex_q.rs);
        wb_wr_b  = ex_b_live && writes(wb_q.valid, wb_q.reg_write, wb_q.rd, ex_q.rt);

        // MEM holds the younger result, so it takes priority over WB.
        ex_fwd_a = 2'b00;
        ex_fwd_b = 2'b00;
        if (FWD_EN && rst_n) begin
            if (mem_wr_a)     ex_fwd_a = 2'b01;
            else if (wb_wr_a) ex_fwd_a = 2'b10;
            if (mem_wr_b)     ex_fwd_b = 2'b01;
            else if (wb_wr_b) ex_fwd_b = 2'b10;
        end

        // Register file writes at the end of WB, so ID must bypass it.
        id_byp_a = FWD_EN && rst_n && id_a_live &&
                   writes(wb_q.valid, wb_q.reg_write, wb_q.rd, id_rs);
        id_byp_b = FWD_EN && rst_n && id_b_live &&
                   writes(wb_q.valid, wb_q.reg_write, wb_q.rd, id_rt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            wb_q  <= mem_q;
            // The instruction in EX moves on even on a taken branch; only
            // the younger ones get squashed.
            mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};
            if (id_valid && !stall && !br_taken) begin
                ex_q <= '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write,
                          mem_read: id_mem_read, rs: id_rs, rt: id_rt,
                          rs_used: id_rs_used, rt_used: id_rt_used};
            end else begin
                ex_q <= '0;
            end
            if (stall && (stall_cnt_q != CNT_MAX))
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            if (br_taken && (flush_cnt_q != CNT_MAX))
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_unit
//
// Three hazard units share one ID/branch stimulus stream:
//   dut_a  FWD_EN=1 ZERO_R0=0 CNT_W=16
//   dut_b  FWD_EN=0 ZERO_R0=0 CNT_W=16
//   dut_c  FWD_EN=1 ZERO_R0=1 CNT_W=4
// The driver queues hand-computed expectations tagged with the cycle they
// apply to. The monitor compares them on the falling clock edge, or at once
// when mon_ev fires (used for the asynchronous reset check).
// -----------------------------------------------------------------------------
module tb_pipe_hazard_unit;

  localparam int AW = 6;
  localparam int W  = 54;  // {cycle[31:0], dut[1:0], field[3:0], value[15:0]}

  localparam int D_A = 0, D_B = 1, D_C = 2;
  localparam int F_STALL = 0, F_FI = 1, F_FX = 2, F_FWDA = 3, F_FWDB = 4,
                 F_BYPA = 5, F_BYPB = 6, F_SCNT = 7, F_FCNT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic          id_rs_used = 1'b0, id_rt_used = 1'b0;
  logic          id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic          br_taken = 1'b0;

  logic a_stall, a_fi, a_fx, a_byp_a, a_byp_b;
  logic [1:0] a_fwd_a, a_fwd_b;
  logic [15:0] a_scnt, a_fcnt;
  logic b_stall, b_fi, b_fx, b_byp_a, b_byp_b;
  logic [1:0] b_fwd_a, b_fwd_b;
  logic [15:0] b_scnt, b_fcnt;
  logic c_stall, c_fi, c_fx, c_byp_a, c_byp_b;
  logic [1:0] c_fwd_a, c_fwd_b;
  logic [3:0] c_scnt, c_fcnt;

  pipe_hazard_unit #(.REG_AW(AW), .FWD_EN(1'b1), .ZERO_R0(1'b0), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .br_taken(br_taken),
    .stall(a_stall), .flush_ifid(a_fi), .flush_idex(a_fx),
    .ex_fwd_a(a_fwd_a), .ex_fwd_b(a_fwd_b), .id_byp_a(a_byp_a), .id_byp_b(a_byp_b),
    .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

  pipe_hazard_unit #(.REG_AW(AW), .FWD_EN(1'b0), .ZERO_R0(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .br_taken(br_taken),
    .stall(b_stall), .flush_ifid(b_fi), .flush_idex(b_fx),
    .ex_fwd_a(b_fwd_a), .ex_fwd_b(b_fwd_b), .id_byp_a(b_byp_a), .id_byp_b(b_byp_b),
    .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

  pipe_hazard_unit #(.REG_AW(AW), .FWD_EN(1'b1), .ZERO_R0(1'b1), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .br_taken(br_taken),
    .stall(c_stall), .flush_ifid(c_fi), .flush_idex(c_fx),
    .ex_fwd_a(c_fwd_a), .ex_fwd_b(c_fwd_b), .id_byp_a(c_byp_a), .id_byp_b(c_byp_b),
    .stall_cnt(c_scnt), .flush_cnt(c_fcnt));

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;
  event mon_ev;

  function automatic string fld_name(input int f);
    case (f)
      F_STALL: return "stall";
      F_FI:    return "flush_ifid";
      F_FX:    return "flush_idex";
      F_FWDA:  return "ex_fwd_a";
      F_FWDB:  return "ex_fwd_b";
      F_BYPA:  return "id_byp_a";
      F_BYPB:  return "id_byp_b";
      F_SCNT:  return "stall_cnt";
      default: return "flush_cnt";
    endcase
  endfunction

  function automatic logic [15:0] get_act(input int d, input int f);
    logic [15:0] v [0:8];
    if (d == D_A) begin
      v = '{{15'd0, a_stall}, {15'd0, a_fi}, {15'd0, a_fx}, {14'd0, a_fwd_a},
            {14'd0, a_fwd_b}, {15'd0, a_byp_a}, {15'd0, a_byp_b}, a_scnt, a_fcnt};
    end else if (d == D_B) begin
      v = '{{15'd0, b_stall}, {15'd0, b_fi}, {15'd0, b_fx}, {14'd0, b_fwd_a},
            {14'd0, b_fwd_b}, {15'd0, b_byp_a}, {15'd0, b_byp_b}, b_scnt, b_fcnt};
    end else begin
      v = '{{15'd0, c_stall}, {15'd0, c_fi}, {15'd0, c_fx}, {14'd0, c_fwd_a},
            {14'd0, c_fwd_b}, {15'd0, c_byp_a}, {15'd0, c_byp_b},
            {12'd0, c_scnt}, {12'd0, c_fcnt}};
    end
    return v[f];
  endfunction

  task automatic exp_out(input int d, input int f, input int val);
    logic [31:0] cv;
    logic [1:0]  dv;
    logic [3:0]  fv;
    logic [15:0] vv;
    cv = cyc_n;
    dv = d[1:0];
    fv = f[3:0];
    vv = val[15:0];
    exp_q.push_back({cv, dv, fv, vv});
  endtask

  task automatic check_due();
    logic [W-1:0] e;
    int tag, d, f;
    logic [15:0] act, expv;
    while (exp_q.size() > 0 && int'(exp_q[0][W-1:22]) <= cyc_n) begin
      e    = exp_q.pop_front();
      tag  = int'(e[W-1:22]);
      d    = int'(e[21:20]);
      f    = int'(e[19:16]);
      expv = e[15:0];
      act  = get_act(d, f);
      chk_cnt++;
      if (tag != cyc_n)
        $display("FAIL %s dut%0d cyc%0d: check not sampled in its cycle (now %0d)",
                 fld_name(f), d, tag, cyc_n);
      else if (act === expv)
        pass_cnt++;
      else
        $display("FAIL %s dut%0d cyc%0d: got %0d expected %0d",
                 fld_name(f), d, tag, act, expv);
    end
  endtask

  always begin
    @(negedge clk or mon_ev);
    check_due();
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input int rd, input int rs, input int rt,
                        input logic ru, input logic tu, input logic rw,
                        input logic mr, input logic br);
    id_valid     = v;
    id_rd        = AW'(rd);
    id_rs        = AW'(rs);
    id_rt        = AW'(rt);
    id_rs_used   = ru;
    id_rt_used   = tu;
    id_reg_write = rw;
    id_mem_read  = mr;
    br_taken     = br;
  endtask

  task automatic nop();
    id_set(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Leaves the bench just after a clock edge with rst_n released and an
  // empty pipeline; the next edge is the first one out of reset.
  task automatic do_reset();
    rst_n = 1'b0;
    nop();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // Reset state: a taken branch and a real instruction must not leak out.
    id_set(1'b1, 5, 5, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    exp_out(D_A, F_STALL, 0); exp_out(D_A, F_FI, 0); exp_out(D_A, F_FX, 0);
    exp_out(D_A, F_SCNT, 0);  exp_out(D_A, F_FCNT, 0); exp_out(D_B, F_FI, 0);
    tick();
    do_reset();

    // Load-use with forwarding: lw r5 ; add r7,r5,r6.
    id_set(1'b1, 5, 1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_out(D_A, F_STALL, 0);
    tick();
    id_set(1'b1, 7, 5, 6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_out(D_A, F_STALL, 1); exp_out(D_A, F_SCNT, 0);
    tick();
    exp_out(D_A, F_STALL, 0); exp_out(D_A, F_SCNT, 1);
    tick();
    nop();
    exp_out(D_A, F_FWDA, 2); exp_out(D_A, F_FWDB, 0);
    exp_out(D_A, F_STALL, 0); exp_out(D_A, F_SCNT, 1);
    tick();
    do_reset();

    // ALU chains: add r3 ; sub r4,r3,r3 ; then one-nop and two-nop gaps.
    id_set(1'b1, 3, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    id_set(1'b1, 4, 3, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_out(D_A, F_STALL, 0);
    tick();
    id_set(1'b1, 3, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_out(D_A, F_FWDA, 1); exp_out(D_A, F_FWDB, 1);
    tick();
    nop();
    exp_out(D_A, F_FWDA, 0);
    tick();
    id_set(1'b1, 4, 3, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_out(D_A, F_BYPA, 0); exp_out(D_A, F_STALL, 0);
    tick();
    nop();
    exp_out(D_A, F_FWDA, 2); exp_out(D_A, F_FWDB, 2);
    tick();
    id_set(1'b1, 3, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    tick();
    tick();
    id_set(1'b1, 4, 3, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_out(D_A, F_BYPA, 1); exp_out(D_A, F_BYPB, 1);
    exp_out(D_A, F_FWDA, 0); exp_out(D_A, F_SCNT, 0);
    tick();
    do_reset();

    // Taken branch over a load-use: lw r5 in EX, lw r9,(r5) in ID.
    id_set(1'b1, 5, 1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    id_set(1'b1, 9, 5, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    exp_out(D_A, F_STALL, 0); exp_out(D_A, F_FI, 1); exp_out(D_A, F_FX, 1);
    exp_out(D_A, F_FCNT, 0);
    tick();
    // A leaked lw r9 in EX would stall this add r10,r9,r5.
    id_set(1'b1, 10, 9, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_out(D_A, F_STALL, 0); exp_out(D_A, F_FI, 0); exp_out(D_A, F_FX, 0);
    exp_out(D_A, F_FCNT, 1); exp_out(D_A, F_SCNT, 0);
    tick();
    // lw r5 survived the branch and now sits in WB.
    nop();
    exp_out(D_A, F_FWDA, 0); exp_out(D_A, F_FWDB, 2);
    tick();
    do_reset();

    // Stall-only mode: add r3 ; or r8,r3,r0.
    id_set(1'b1, 3, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_out(D_B, F_STALL, 0);
    tick();
    id_set(1'b1, 8, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_out(D_B, F_STALL, 1); exp_out(D_B, F_FWDA, 0);
    tick();
    exp_out(D_B, F_STALL, 1); exp_out(D_B, F_SCNT, 1);
    tick();
    exp_out(D_B, F_STALL, 1); exp_out(D_B, F_BYPA, 0); exp_out(D_B, F_BYPB, 0);
    tick();
    exp_out(D_B, F_STALL, 0); exp_out(D_B, F_SCNT, 3);
    tick();
    do_reset();

    // Hardwired r0: lw r0 ; add r1,r0,r0.
    id_set(1'b1, 0, 1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    id_set(1'b1, 1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_out(D_C, F_STALL, 0); exp_out(D_A, F_STALL, 1);
    tick();
    nop();
    exp_out(D_C, F_FWDA, 0); exp_out(D_C, F_FWDB, 0);
    tick();
    do_reset();

    // Saturation: lw r5,(r5) held in ID stalls on every other cycle.
    id_set(1'b1, 5, 5, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 41; k++) begin
      if (k == 29) exp_out(D_C, F_SCNT, 14);
      if (k == 40) begin
        exp_out(D_C, F_SCNT, 15); exp_out(D_A, F_SCNT, 20);
        exp_out(D_A, F_STALL, 0);
      end
      tick();
    end

    // Asynchronous reset in the middle of a stall cycle.
    exp_out(D_A, F_STALL, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    exp_out(D_A, F_STALL, 0); exp_out(D_A, F_SCNT, 0);
    exp_out(D_C, F_SCNT, 0);  exp_out(D_A, F_FCNT, 0);
    #1;
    ->mon_ev;
    tick();
    tick();
    rst_n = 1'b1;
    // First cycle after release sees an empty pipeline.
    exp_out(D_A, F_STALL, 0); exp_out(D_A, F_SCNT, 0);
    tick();
    exp_out(D_A, F_STALL, 1);
    tick();
    nop();

    // Drain, bounded.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) tick();
    while (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      chk_cnt++;
      $display("FAIL drain: expectation never checked, got none expected a sample");
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got %0d/%0d", pass_cnt, chk_cnt);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1, "timeout");
  end

endmodule
